rob_commit_ctrl: RTL
====================

ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

Interface
REQ-001 Parameter ROB_DEPTH, default 16, number of reorder entries; SHALL be a power of two.
REQ-002 Parameter TAG_W, default 4, entry tag width; SHALL equal log2(ROB_DEPTH).
REQ-003 clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 rdy_in  input  1  global enable; low SHALL freeze all state and registered outputs.
REQ-006 alloc_en_in  input  1  dispatcher requests one entry this cycle.
REQ-007 alloc_rd_in  input  5  destination architectural register of the allocating instruction.
REQ-008 alloc_tag_out  output  TAG_W  tag granted on allocation (current tail, combinational).
REQ-009 full_out / empty_out  output  1 each  count==ROB_DEPTH / count==0.
REQ-010 cdb_en_in, cdb_tag_in (TAG_W), cdb_value_in (32)  input  result broadcast marking an entry ready.
REQ-011 q1_tag_in, q2_tag_in  input  TAG_W  operand lookup tags from the dispatcher.
REQ-012 q1_ready_out, q2_ready_out (1), q1_value_out, q2_value_out (32)  output  combinational lookup results.
REQ-013 reg_en_out (1), reg_pos_out (5), reg_dest_out (TAG_W), reg_value_out (32)  output  registered commit write to the register file.
REQ-014 flush_in  input  1  mispredict flush; reg_flush_out  output  1  registered pulse telling the register file to clear all busy bits.

Function
REQ-015 Entries SHALL form a circular buffer: head (oldest), tail (next free), count of TAG_W+1 bits; head/tail SHALL wrap modulo ROB_DEPTH.
REQ-016 Allocation: alloc_en_in & !full_out SHALL write {valid=1, ready=0, rd=alloc_rd_in} at tail, tail+1, count+1; alloc_en_in while full SHALL be ignored.
REQ-017 Full is evaluated on pre-edge count; allocation while full SHALL be refused even if a commit occurs the same cycle.
REQ-018 CDB: cdb_en_in to a valid entry SHALL set ready=1 and store cdb_value_in; CDB to an invalid entry SHALL be ignored.
REQ-019 Lookup: qN_ready_out SHALL be 1 if entry qN_tag_in is valid & ready, or cdb_en_in with cdb_tag_in==qN_tag_in (bypass, value from cdb_value_in); otherwise 0 with value 0.
REQ-020 Commit: when head entry is valid & ready, SHALL retire it in one cycle: head+1, count-1, valid=0; at most one commit per cycle.
REQ-021 On commit with rd!=0, next cycle SHALL present reg_en_out=1, reg_pos_out=rd, reg_dest_out=old head tag, reg_value_out=value; with rd==0 entry retires and reg_en_out SHALL be 0.
REQ-022 reg_en_out SHALL be a one-cycle pulse per commit (cleared on next rdy_in-high edge absent a new commit).
REQ-023 Simultaneous alloc+commit SHALL leave count unchanged; a CDB hitting the head entry SHALL make it committable no earlier than the next cycle.
REQ-024 Flush: flush_in SHALL have priority over alloc, CDB and commit that cycle: all valid=0, head=tail=count=0, reg_en_out=0, reg_flush_out=1 next cycle for exactly one cycle.
REQ-025 rdy_in low SHALL hold every register including reg_en_out and reg_flush_out, so each pulse is consumed exactly once.

Reset
REQ-026 rst_in SHALL clear head, tail, count, all valid/ready bits, reg_en_out, reg_pos_out, reg_dest_out, reg_value_out, reg_flush_out to 0, independent of rdy_in.
REQ-027 Reset mid-operation SHALL discard all in-flight entries; empty_out=1, full_out=0 the following cycle.

Structure
REQ-028 ROB_DEPTH, TAG_W, register-index width (5) and data width (32) SHALL live in the shared define header.
REQ-029 Head/tail/count management SHALL be one sub-module, rob_ptr_ctrl (inputs: push, pop, flush; outputs: head, tail, full, empty).

Verification
REQ-030 Reset, alloc rd=5 tag0, CDB tag0 value 0xDEADBEEF -> two cycles later reg_en_out=1, reg_pos_out=5, reg_dest_out=0, reg_value_out=0xDEADBEEF; empty_out=1.
REQ-031 Allocate 16 entries -> full_out=1; 17th alloc ignored; CDB tags 15..0 in reverse order -> commits emerge strictly tag 0..15, one per cycle.
REQ-032 Alloc rd=0, CDB ready -> entry retires, reg_en_out stays 0, count decrements.
REQ-033 q1_tag_in=3 with same-cycle CDB tag3 value 0x12 -> q1_ready_out=1, q1_value_out=0x12 before entry updates.
REQ-034 Fill 6 entries, assert flush_in with concurrent alloc and CDB -> reg_flush_out pulses once, count=0, no reg_en_out, next alloc gets tag 0.
REQ-035 Commit pending, rdy_in low 3 cycles -> reg_en_out held high, then exactly one write after rdy_in returns.

Source files
------------

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared sizing constants for the reorder-buffer commit controller.
//   ROB_DEPTH_DEF : default number of reorder entries (power of two)
//   TAG_W_DEF     : default entry tag width, log2(ROB_DEPTH_DEF)
//   REG_W         : architectural register index width
//   DATA_W        : result data width
package rob_commit_ctrl_pkg;
    localparam int unsigned ROB_DEPTH_DEF = 16;
    localparam int unsigned TAG_W_DEF     = 4;
    localparam int unsigned REG_W         = 5;
    localparam int unsigned DATA_W        = 32;
endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer circular queue.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   en              : global enable; low holds all state
//   push, pop       : allocate at tail / retire at head this cycle
//   flush           : empties the queue, overriding push and pop
//   head, tail      : oldest entry / next free entry
//   full, empty     : occupancy == DEPTH / occupancy == 0
module rob_ptr_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic [TAG_W-1:0] head,
    output logic [TAG_W-1:0] tail,
    output logic             full,
    output logic             empty
);
    logic [TAG_W:0] count;

    assign full  = (count == (TAG_W+1)'(DEPTH));
    assign empty = (count == '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (en) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head <= head + TAG_W'(pop);
                tail <= tail + TAG_W'(push);
                if (push && !pop)
                    count <= count + (TAG_W+1)'(1);
                else if (pop && !push)
                    count <= count - (TAG_W+1)'(1);
            end
        end
    end
endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder buffer commit controller: allocates entries in program order,
// marks them ready from the result bus, answers operand lookups (with
// same-cycle result bypass) and retires the oldest ready entry into a
// registered register-file write.
// Ports:
//   clk_in, rst_in, rdy_in                 : clock, sync reset, global enable
//   alloc_en_in, alloc_rd_in, alloc_tag_out : allocation request / granted tag
//   full_out, empty_out                    : occupancy status
//   cdb_en_in, cdb_tag_in, cdb_value_in    : result broadcast
//   q1/q2_tag_in, q1/q2_ready_out, q1/q2_value_out : operand lookup
//   reg_en_out, reg_pos_out, reg_dest_out, reg_value_out : commit write
//   flush_in, reg_flush_out                : mispredict flush / busy-clear pulse
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int unsigned TAG_W     = TAG_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              alloc_en_in,
    input  logic [REG_W-1:0]  alloc_rd_in,
    output logic [TAG_W-1:0]  alloc_tag_out,
    output logic              full_out,
    output logic              empty_out,
    input  logic              cdb_en_in,
    input  logic [TAG_W-1:0]  cdb_tag_in,
    input  logic [DATA_W-1:0] cdb_value_in,
    input  logic [TAG_W-1:0]  q1_tag_in,
    input  logic [TAG_W-1:0]  q2_tag_in,
    output logic              q1_ready_out,
    output logic              q2_ready_out,
    output logic [DATA_W-1:0] q1_value_out,
    output logic [DATA_W-1:0] q2_value_out,
    output logic              reg_en_out,
    output logic [REG_W-1:0]  reg_pos_out,
    output logic [TAG_W-1:0]  reg_dest_out,
    output logic [DATA_W-1:0] reg_value_out,
    input  logic              flush_in,
    output logic              reg_flush_out
);
    logic [ROB_DEPTH-1:0] valid;
    logic [ROB_DEPTH-1:0] ready;
    logic [REG_W-1:0]     rd_q  [ROB_DEPTH];
    logic [DATA_W-1:0]    val_q [ROB_DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic             push;
    logic             commit;
    logic             cdb_hit;

    // Full is the pre-edge value, so a same-cycle commit never frees a slot
    // for the allocation happening on that edge.
    assign push    = alloc_en_in && !full_out;
    assign commit  = valid[head] && ready[head];
    assign cdb_hit = cdb_en_in && valid[cdb_tag_in];

    assign alloc_tag_out = tail;

    rob_ptr_ctrl #(
        .DEPTH (ROB_DEPTH),
        .TAG_W (TAG_W)
    ) u_ptr (
        .clk   (clk_in),
        .rst   (rst_in),
        .en    (rdy_in),
        .push  (push),
        .pop   (commit),
        .flush (flush_in),
        .head  (head),
        .tail  (tail),
        .full  (full_out),
        .empty (empty_out)
    );

    // Later assignments win: a commit retires the head even if the CDB also
    // targets it, and allocation only ever hits an invalid slot.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid <= '0;
            ready <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                valid <= '0;
                ready <= '0;
            end else begin
                if (cdb_hit)
                    ready[cdb_tag_in] <= 1'b1;
                if (commit) begin
                    valid[head] <= 1'b0;
                    ready[head] <= 1'b0;
                end
                if (push) begin
                    valid[tail] <= 1'b1;
                    ready[tail] <= 1'b0;
                end
            end
        end
    end

    // Payload storage is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush_in) begin
            if (push)
                rd_q[tail] <= alloc_rd_in;
            if (cdb_hit)
                val_q[cdb_tag_in] <= cdb_value_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            reg_en_out    <= 1'b0;
            reg_pos_out   <= '0;
            reg_dest_out  <= '0;
            reg_value_out <= '0;
            reg_flush_out <= 1'b0;
        end else if (rdy_in) begin
            if (flush_in) begin
                reg_en_out    <= 1'b0;
                reg_flush_out <= 1'b1;
            end else begin
                reg_flush_out <= 1'b0;
                reg_en_out    <= commit && (rd_q[head] != '0);
                if (commit) begin
                    reg_pos_out   <= rd_q[head];
                    reg_dest_out  <= head;
                    reg_value_out <= val_q[head];
                end
            end
        end
    end

    // The broadcast bypass takes precedence, giving the newest value.
    always_comb begin
        q1_ready_out = 1'b0;
        q1_value_out = '0;
        q2_ready_out = 1'b0;
        q2_value_out = '0;
        if (cdb_en_in && cdb_tag_in == q1_tag_in) begin
            q1_ready_out = 1'b1;
            q1_value_out = cdb_value_in;
        end else if (valid[q1_tag_in] && ready[q1_tag_in]) begin
            q1_ready_out = 1'b1;
            q1_value_out = val_q[q1_tag_in];
        end
        if (cdb_en_in && cdb_tag_in == q2_tag_in) begin
            q2_ready_out = 1'b1;
            q2_value_out = cdb_value_in;
        end else if (valid[q2_tag_in] && ready[q2_tag_in]) begin
            q2_ready_out = 1'b1;
            q2_value_out = val_q[q2_tag_in];
        end
    end
endmodule
